// File: rtl/xlate_stage_pkg.sv
// rtl/xlate_stage_pkg.sv - shared widths and region tags for the address translation stage
package xlate_stage_pkg;
  localparam int VA_W   = 32;
  localparam int PAGE_W = 20;
  localparam int OFF_W  = 12;
  localparam logic [1:0] DIRECT_TAG = 2'b11;
endpackage

// File: rtl/xlate_stage_cam.sv
// rtl/xlate_stage_cam.sv - fully associative page table with valid bits, lowest-index priority
// match and a registered read port
module xlate_cam
  import xlate_stage_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAGE_W-1:0] lookup_page,
  output logic              hit,
  output logic [PAGE_W-1:0] hit_frame,
  input  logic [IDX_W-1:0]  tlb_index,
  input  logic              tlb_wen,
  input  logic [PAGE_W-1:0] tlb_wpage,
  input  logic [PAGE_W-1:0] tlb_wframe,
  input  logic              tlb_flush,
  output logic [PAGE_W-1:0] tlb_rpage,
  output logic [PAGE_W-1:0] tlb_rframe,
  output logic              tlb_rvalid
);
  logic [PAGE_W-1:0] page_q  [ENTRIES];
  logic [PAGE_W-1:0] frame_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  // Scan from the top down so the lowest matching index is the last assignment.
  always_comb begin
    hit       = 1'b0;
    hit_frame = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (page_q[i] == lookup_page)) begin
        hit       = 1'b1;
        hit_frame = frame_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tlb_wen) begin
      page_q[tlb_index]  <= tlb_wpage;
      frame_q[tlb_index] <= tlb_wframe;
    end
  end

  // Write after flush so a same-cycle write leaves its entry valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (tlb_flush)
        valid_q <= '0;
      if (tlb_wen)
        valid_q[tlb_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tlb_rpage  <= '0;
      tlb_rframe <= '0;
      tlb_rvalid <= 1'b0;
    end else if (!tlb_wen) begin
      tlb_rpage  <= page_q[tlb_index];
      tlb_rframe <= frame_q[tlb_index];
      tlb_rvalid <= valid_q[tlb_index];
    end
  end
endmodule

// File: rtl/xlate_stage.sv
// rtl/xlate_stage.sv - single-cycle virtual to physical translation stage with ready/valid
// handshake, direct-mapped high region and random replacement hint
module xlate_stage
  import xlate_stage_pkg::*;
#(
  parameter int ENTRIES   = 32,
  parameter int PA_W      = 30,
  parameter int WIRED     = 4,
  parameter int DIRECT_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       in_ready,
  input  logic                       in_valid,
  input  logic [VA_W-1:0]            in_vaddr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [PA_W-1:0]            out_paddr,
  output logic                       out_miss,
  input  logic [$clog2(ENTRIES)-1:0] tlb_index,
  input  logic                       tlb_wen,
  input  logic [PAGE_W-1:0]          tlb_wpage,
  input  logic [PAGE_W-1:0]          tlb_wframe,
  input  logic                       tlb_flush,
  output logic [PAGE_W-1:0]          tlb_rpage,
  output logic [PAGE_W-1:0]          tlb_rframe,
  output logic                       tlb_rvalid,
  output logic [$clog2(ENTRIES)-1:0] tlb_random
);
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int FRAME_W = PA_W - OFF_W;

  logic              hit;
  logic [PAGE_W-1:0] hit_frame;
  logic [PA_W-1:0]   paddr_d;
  logic              miss_d;
  logic              unused_bits;

  xlate_cam #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cam (
    .clk        (clk),
    .rst        (rst),
    .lookup_page(in_vaddr[VA_W-1:OFF_W]),
    .hit        (hit),
    .hit_frame  (hit_frame),
    .tlb_index  (tlb_index),
    .tlb_wen    (tlb_wen),
    .tlb_wpage  (tlb_wpage),
    .tlb_wframe (tlb_wframe),
    .tlb_flush  (tlb_flush),
    .tlb_rpage  (tlb_rpage),
    .tlb_rframe (tlb_rframe),
    .tlb_rvalid (tlb_rvalid)
  );

  assign in_ready    = out_ready | ~out_valid;
  assign unused_bits = ^{in_vaddr, hit_frame};

  always_comb begin
    paddr_d = {{FRAME_W{1'b0}}, in_vaddr[OFF_W-1:0]};
    miss_d  = 1'b1;
    if ((DIRECT_EN != 0) && (in_vaddr[VA_W-1:VA_W-2] == DIRECT_TAG)) begin
      paddr_d = in_vaddr[PA_W-1:0];
      miss_d  = 1'b0;
    end else if (hit) begin
      paddr_d = {hit_frame[PAGE_W-1 -: FRAME_W], in_vaddr[OFF_W-1:0]};
      miss_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_paddr <= '0;
      out_miss  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_paddr <= paddr_d;
        out_miss  <= miss_d;
      end
    end
  end

  // Counts down through the non-wired entries; pinned when only one entry is replaceable.
  always_ff @(posedge clk) begin
    if (!rst || (tlb_random == IDX_W'(WIRED)))
      tlb_random <= IDX_W'(ENTRIES - 1);
    else
      tlb_random <= tlb_random - 1'b1;
  end
endmodule

// File: tb/tb_xlate_stage.sv
// tb/tb_xlate_stage.sv - directed bench for xlate_stage with default parameters
module tb_xlate_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_ready;
  logic        in_valid = 1'b0;
  logic [31:0] in_vaddr = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [29:0] out_paddr;
  logic        out_miss;
  logic [4:0]  tlb_index = '0;
  logic        tlb_wen = 1'b0;
  logic [19:0] tlb_wpage = '0;
  logic [19:0] tlb_wframe = '0;
  logic        tlb_flush = 1'b0;
  logic [19:0] tlb_rpage;
  logic [19:0] tlb_rframe;
  logic        tlb_rvalid;
  logic [4:0]  tlb_random;

  int vectors = 0;
  int miscompares = 0;

  xlate_stage dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_valid(in_valid), .in_vaddr(in_vaddr),
    .out_ready(out_ready), .out_valid(out_valid), .out_paddr(out_paddr), .out_miss(out_miss),
    .tlb_index(tlb_index), .tlb_wen(tlb_wen), .tlb_wpage(tlb_wpage), .tlb_wframe(tlb_wframe),
    .tlb_flush(tlb_flush), .tlb_rpage(tlb_rpage), .tlb_rframe(tlb_rframe),
    .tlb_rvalid(tlb_rvalid), .tlb_random(tlb_random)
  );

  always #5 clk = ~clk;

  task automatic write_entry(input logic [4:0] idx, input logic [19:0] page,
                             input logic [19:0] frame, input logic flush);
    @(negedge clk);
    tlb_index = idx; tlb_wpage = page; tlb_wframe = frame; tlb_wen = 1'b1; tlb_flush = flush;
    @(negedge clk);
    tlb_wen = 1'b0; tlb_flush = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] va, output logic v, output logic [29:0] pa,
                           output logic m);
    @(negedge clk);
    in_valid = 1'b1; in_vaddr = va;
    @(negedge clk);
    v = out_valid; pa = out_paddr; m = out_miss;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_miss !== 1'b0 || out_paddr !== 30'h0) begin
      miscompares++;
      $display("FAIL reset_out: valid=%b miss=%b paddr=%h want 0 0 0", out_valid, out_miss, out_paddr);
    end
    vectors++;
    if (tlb_rpage !== 20'h0 || tlb_rframe !== 20'h0 || tlb_rvalid !== 1'b0 || tlb_random !== 5'd31) begin
      miscompares++;
      $display("FAIL reset_tlb: rpage=%h rframe=%h rvalid=%b random=%0d want 0 0 0 31",
               tlb_rpage, tlb_rframe, tlb_rvalid, tlb_random);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    int exp_r = 31;
    for (int k = 0; k < 29; k++) begin
      vectors++;
      if (tlb_random !== 5'(exp_r)) begin
        miscompares++;
        $display("FAIL random_seq step %0d: got %0d want %0d", k, tlb_random, exp_r);
      end
      @(negedge clk);
      exp_r = (exp_r == 4) ? 31 : exp_r - 1;
    end
  endtask

  task automatic test_hit_and_read();
    logic v, m; logic [29:0] pa;
    write_entry(5'd3, 20'h00012, 20'h00ABC, 1'b0);
    do_lookup(32'h0001_2345, v, pa, m);
    vectors++;
    if (v !== 1'b1 || pa !== 30'h002AF345 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL hit: valid=%b paddr=%h miss=%b want 1 002af345 0", v, pa, m);
    end
    tlb_index = 5'd3;
    @(negedge clk);
    vectors++;
    if (tlb_rpage !== 20'h00012 || tlb_rframe !== 20'h00ABC || tlb_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL read_port: %h %h %b want 00012 00abc 1", tlb_rpage, tlb_rframe, tlb_rvalid);
    end
    write_entry(5'd6, 20'h00066, 20'h00077, 1'b0);
    vectors++;
    if (tlb_rpage !== 20'h00012 || tlb_rframe !== 20'h00ABC) begin
      miscompares++;
      $display("FAIL read_hold_on_write: %h %h want 00012 00abc", tlb_rpage, tlb_rframe);
    end
  endtask

  task automatic test_miss();
    logic v, m; logic [29:0] pa;
    do_lookup(32'h0009_9000, v, pa, m);
    vectors++;
    if (v !== 1'b1 || pa !== 30'h0 || m !== 1'b1) begin
      miscompares++;
      $display("FAIL miss: valid=%b paddr=%h miss=%b want 1 00000000 1", v, pa, m);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_drop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_direct();
    logic v, m; logic [29:0] pa;
    write_entry(5'd0, 20'hC0001, 20'h55555, 1'b0);
    do_lookup(32'hC000_1234, v, pa, m);
    vectors++;
    if (pa !== 30'h00001234 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL direct: paddr=%h miss=%b want 00001234 0", pa, m);
    end
  endtask

  task automatic test_priority();
    logic v, m; logic [29:0] pa;
    write_entry(5'd9, 20'h00400, 20'h22222, 1'b0);
    write_entry(5'd7, 20'h00400, 20'h11111, 1'b0);
    do_lookup(32'h0040_0ABC, v, pa, m);
    vectors++;
    if (pa !== 30'h04444ABC || m !== 1'b0) begin
      miscompares++;
      $display("FAIL priority: paddr=%h miss=%b want 04444abc 0", pa, m);
    end
  endtask

  task automatic test_write_same_cycle();
    logic v, m; logic [29:0] pa;
    @(negedge clk);
    in_valid = 1'b1; in_vaddr = 32'h0077_7010;
    tlb_index = 5'd10; tlb_wpage = 20'h00777; tlb_wframe = 20'h00ABC; tlb_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; tlb_wen = 1'b0;
    vectors++;
    if (out_paddr !== 30'h00000010 || out_miss !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_edge_lookup: paddr=%h miss=%b want 00000010 1", out_paddr, out_miss);
    end
    do_lookup(32'h0077_7010, v, pa, m);
    vectors++;
    if (pa !== 30'h002AF010 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL post_write_lookup: paddr=%h miss=%b want 002af010 0", pa, m);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_vaddr = 32'h0001_2345; out_ready = 1'b0;
    @(negedge clk);
    in_vaddr = 32'h0009_9000;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_paddr !== 30'h002AF345 || out_miss !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall cycle %0d: valid=%b paddr=%h miss=%b in_ready=%b want 1 002af345 0 0",
                 c, out_valid, out_paddr, out_miss, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_paddr !== 30'h0 || out_miss !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: valid=%b paddr=%h miss=%b want 1 00000000 1",
               out_valid, out_paddr, out_miss);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_write();
    logic v, m; logic [29:0] pa;
    write_entry(5'd5, 20'h00050, 20'h00100, 1'b1);
    do_lookup(32'h0005_0123, v, pa, m);
    vectors++;
    if (pa !== 30'h00040123 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_keep_written: paddr=%h miss=%b want 00040123 0", pa, m);
    end
    do_lookup(32'h0001_2345, v, pa, m);
    vectors++;
    if (pa !== 30'h00000345 || m !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_drop_idx3: paddr=%h miss=%b want 00000345 1", pa, m);
    end
  endtask

  task automatic test_reset_mid();
    logic v, m; logic [29:0] pa;
    @(negedge clk);
    in_valid = 1'b1; in_vaddr = 32'h0005_0123; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || out_paddr !== 30'h0 || out_miss !== 1'b0 || tlb_random !== 5'd31) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b paddr=%h miss=%b random=%0d want 0 0 0 31",
               out_valid, out_paddr, out_miss, tlb_random);
    end
    do_lookup(32'h0005_0123, v, pa, m);
    vectors++;
    if (m !== 1'b1 || pa !== 30'h00000123) begin
      miscompares++;
      $display("FAIL reset_invalidates: paddr=%h miss=%b want 00000123 1", pa, m);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_hit_and_read();
    test_miss();
    test_direct();
    test_priority();
    test_write_same_cycle();
    test_back_to_back();
    test_flush_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
